// File: rtl/cpu_multicycle_p.sv
// Multicycle 8-bit-style CPU with FETCH/EXEC/MEM FSM and I/D busywait stalls.
// Define CPU_SHIFT_EN to enable sll/srl/sra (opcodes 13-15); otherwise they are illegal.
module cpu_multicycle_p #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  output logic              IREAD,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IBUSYWAIT,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  output logic              READ,
  output logic              WRITE,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              BUSYWAIT,
  output logic              ILLEGAL
);

  localparam int NREG = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                iread_q, iread_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                ill_q, ill_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic                we;
  logic [DATA_W-1:0]   wd;

  logic [7:0]            opc;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]     a, b, imm_x;
  logic [31:0]           pc_inc, pc_br;
  logic                  unused_bits;

  assign opc    = instr_q[31:24];
  assign rd     = instr_q[16 +: REG_ADDR_W];
  assign rs1    = instr_q[8 +: REG_ADDR_W];
  assign rs2    = instr_q[0 +: REG_ADDR_W];
  assign a      = regs_q[rs1];
  assign b      = regs_q[rs2];
  assign imm_x  = DATA_W'($signed(instr_q[7:0]));
  assign pc_inc = pc_q + 32'd4;
  assign pc_br  = pc_inc + (32'($signed(instr_q[23:16])) << 2);

  // rs1 byte is only partly used as a register index
  assign unused_bits = ^instr_q[15:8];

`ifdef CPU_SHIFT_EN
  logic [DATA_W-1:0] sll_r, srl_r, sra_r;
  assign sll_r = a << instr_q[7:0];
  assign srl_r = a >> instr_q[7:0];
  assign sra_r = DATA_W'($signed(a) >>> instr_q[7:0]);
`endif

  assign PC        = pc_q;
  assign IREAD     = iread_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;
  assign ILLEGAL   = ill_q;

  // Next-state, bus requests and register write-back
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    iread_d = iread_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ill_d   = 1'b0;
    we      = 1'b0;
    wd      = '0;
    unique case (state_q)
      S_FETCH: begin
        if (!iread_q) begin
          iread_d = 1'b1;
        end else if (!IBUSYWAIT) begin
          instr_d = INSTRUCTION;
          iread_d = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        iread_d = 1'b1;
        state_d = S_FETCH;
        unique case (opc)
          8'd0: begin we = 1'b1; wd = imm_x; end
          8'd1: begin we = 1'b1; wd = b; end
          8'd2: begin we = 1'b1; wd = a + b; end
          8'd3: begin we = 1'b1; wd = a - b; end
          8'd4: begin we = 1'b1; wd = a & b; end
          8'd5: begin we = 1'b1; wd = a | b; end
          8'd6: pc_d = pc_br;
          8'd7: if (a == b) pc_d = pc_br;
          8'd12: if (a != b) pc_d = pc_br;
          8'd8, 8'd9, 8'd10, 8'd11: begin
            pc_d    = pc_q;
            iread_d = 1'b0;
            state_d = S_MEM;
            addr_d  = opc[0] ? imm_x : b;
            read_d  = ~opc[1];
            write_d = opc[1];
            if (opc[1]) wdata_d = a;
          end
`ifdef CPU_SHIFT_EN
          8'd13: begin we = 1'b1; wd = sll_r; end
          8'd14: begin we = 1'b1; wd = srl_r; end
          8'd15: begin we = 1'b1; wd = sra_r; end
`endif
          default: ill_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (!BUSYWAIT) begin
          if (read_q) begin
            we = 1'b1;
            wd = READDATA;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          pc_d    = pc_inc;
          iread_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, datapath and register-file update; reset aborts any access
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      iread_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ill_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      iread_q <= iread_d;
      read_q  <= read_d;
      write_q <= write_d;
      ill_q   <= ill_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (we) regs_q[rd] <= wd;
    end
  end

endmodule
